// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared definitions for the keypad entry controller.
//   state_t          FSM state encoding
//   MAX_DIGITS_DEF   default digits accepted per number
//   VAL_W_DEF        default width of the assembled value
//   is_onehot10      true when exactly one of ten key bits is set
package keypad_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam int MAX_DIGITS_DEF = 4;
  localparam int VAL_W_DEF      = 14;

  function automatic logic is_onehot10(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad-side and result-side signals of the entry controller.
//   key_in/enter/clear  level inputs from the keypad
//   num_value/num_valid/num_ready  committed-value handshake
//   digit_count/key_error/busy  status
// slave = controller side, master = keypad/downstream side.
interface keypad_entry_ctrl_if
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int VAL_W = VAL_W_DEF
) ();
  logic [9:0]       key_in;
  logic             enter;
  logic             clear;
  logic [VAL_W-1:0] num_value;
  logic             num_valid;
  logic             num_ready;
  logic [2:0]       digit_count;
  logic             key_error;
  logic             busy;

  modport master (
    output key_in, enter, clear, num_ready,
    input  num_value, num_valid, digit_count, key_error, busy
  );

  modport slave (
    input  key_in, enter, clear, num_ready,
    output num_value, num_valid, digit_count, key_error, busy
  );
endinterface

// File: rtl/keypad_entry_ctrl_key_event_detect.sv
// Registers the raw keypad levels once and turns rising edges of the
// registered levels into single-cycle events.
//   clk, rst      clock, async active-high reset
//   key_in        ten digit key levels
//   enter, clear  command levels
//   digit_evt     a single key pressed from an all-released keypad
//   digit_val     index of that key (valid with digit_evt)
//   enter_evt     rising edge of registered enter
//   clear_evt     rising edge of registered clear
//   multi_err     keypad left all-released with more than one key
module key_event_detect
  import keypad_entry_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_in,
  input  logic       enter,
  input  logic       clear,
  output logic       digit_evt,
  output logic [3:0] digit_val,
  output logic       enter_evt,
  output logic       clear_evt,
  output logic       multi_err
);

  logic [9:0] r_key;
  logic [9:0] r_key_prev;
  logic       r_enter;
  logic       r_enter_prev;
  logic       r_clear;
  logic       r_clear_prev;
  logic       w_key_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key        <= '0;
      r_key_prev   <= '0;
      r_enter      <= 1'b0;
      r_enter_prev <= 1'b0;
      r_clear      <= 1'b0;
      r_clear_prev <= 1'b0;
    end else begin
      r_key        <= key_in;
      r_key_prev   <= r_key;
      r_enter      <= enter;
      r_enter_prev <= r_enter;
      r_clear      <= clear;
      r_clear_prev <= r_clear;
    end
  end

  // Only a press out of the fully released state counts, so holding a key
  // or rolling onto a second key never generates another event.
  assign w_key_rise = (r_key_prev == 10'd0) && (r_key != 10'd0);
  assign digit_evt  = w_key_rise && is_onehot10(r_key);
  assign multi_err  = w_key_rise && !is_onehot10(r_key);
  assign enter_evt  = r_enter && !r_enter_prev;
  assign clear_evt  = r_clear && !r_clear_prev;

  always_comb begin
    digit_val = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (r_key[i]) digit_val = 4'(i);
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad number entry: accumulates decimal digits into a binary value and
// hands it downstream with a valid/ready handshake.
//   clk, rst  clock, async active-high reset
//   bus       keypad_entry_ctrl_if.slave (keys, commands, result, status)
//
// state | meaning
// IDLE  | no digits entered
// ENTRY | 1..MAX_DIGITS-1 digits entered
// FULL  | MAX_DIGITS digits entered, further digits flagged as errors
// HOLD  | committed value waiting for num_ready
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF,
  parameter int VAL_W      = VAL_W_DEF
) (
  input logic                clk,
  input logic                rst,
  keypad_entry_ctrl_if.slave bus
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t           r_state, w_state_nxt;
  logic [VAL_W-1:0] r_acc, w_acc_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [VAL_W-1:0] r_val, w_val_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_key_error, w_key_error_nxt;

  logic             w_digit_evt;
  logic [3:0]       w_digit_val;
  logic             w_enter_evt;
  logic             w_clear_evt;
  logic             w_multi_err;
  logic [VAL_W-1:0] w_acc_dig;
  logic [2:0]       w_cnt_inc;

  key_event_detect u_key_event_detect (
    .clk       (clk),
    .rst       (rst),
    .key_in    (bus.key_in),
    .enter     (bus.enter),
    .clear     (bus.clear),
    .digit_evt (w_digit_evt),
    .digit_val (w_digit_val),
    .enter_evt (w_enter_evt),
    .clear_evt (w_clear_evt),
    .multi_err (w_multi_err)
  );

  assign w_acc_dig = (r_acc * VAL_W'(10)) + {{(VAL_W-4){1'b0}}, w_digit_val};
  assign w_cnt_inc = r_cnt + 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_val       <= '0;
      r_valid     <= 1'b0;
      r_key_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_val       <= w_val_nxt;
      r_valid     <= w_valid_nxt;
      r_key_error <= w_key_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_val_nxt       = r_val;
    w_valid_nxt     = r_valid;
    w_key_error_nxt = 1'b0;

    // Clear beats enter beats digit; anything lower in the same cycle is dropped.
    if (w_clear_evt) begin
      w_state_nxt = ST_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_val_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_valid && bus.num_ready) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
          end
          if (w_multi_err) w_key_error_nxt = 1'b1;
        end
        default: begin
          if (w_enter_evt) begin
            w_val_nxt   = r_acc;
            w_valid_nxt = 1'b1;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_HOLD;
          end else if (w_digit_evt) begin
            if (r_state == ST_FULL) begin
              w_key_error_nxt = 1'b1;
            end else begin
              w_acc_nxt   = w_acc_dig;
              w_cnt_nxt   = w_cnt_inc;
              w_state_nxt = (w_cnt_inc == MAX_CNT) ? ST_FULL : ST_ENTRY;
            end
          end else if (w_multi_err) begin
            w_key_error_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.num_value   = r_val;
  assign bus.num_valid   = r_valid;
  assign bus.digit_count = r_cnt;
  assign bus.key_error   = r_key_error;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
module tb_keypad_entry_ctrl;
  import keypad_entry_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   err_cnt;
  int   vld_cycles;

  keypad_entry_ctrl_if #(.VAL_W(14)) bus ();

  keypad_entry_ctrl #(.MAX_DIGITS(4), .VAL_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (bus.key_error) err_cnt++;
    if (bus.num_valid) vld_cycles++;
  endtask

  task automatic press(input int d);
    bus.key_in = 10'(1 << d);
    tick; tick;
    bus.key_in = 10'd0;
    tick; tick;
  endtask

  task automatic do_enter;
    bus.enter = 1'b1;
    tick; tick;
    bus.enter = 1'b0;
  endtask

  task automatic do_clear;
    bus.clear = 1'b1;
    tick; tick;
    bus.clear = 1'b0;
    tick; tick;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    err_cnt    = 0;
    vld_cycles = 0;
    bus.key_in    = 10'd0;
    bus.enter     = 1'b0;
    bus.clear     = 1'b0;
    bus.num_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_valid", int'(bus.num_valid), 0);
    chk("rst_value", int'(bus.num_value), 0);
    chk("rst_count", int'(bus.digit_count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_err", int'(bus.key_error), 0);
    tick; tick;
    rst = 1'b0;
    tick;

    // 4,2,0 then enter with ready high; first press also checks latency
    bus.key_in = 10'(1 << 4);
    tick;
    chk("lat_cnt_k", int'(bus.digit_count), 0);
    tick;
    chk("lat_cnt_k1", int'(bus.digit_count), 1);
    bus.key_in = 10'd0;
    tick; tick;
    press(2);
    press(0);
    chk("e420_cnt", int'(bus.digit_count), 3);
    chk("e420_acc", int'(dut.r_acc), 420);
    chk("e420_busy", int'(bus.busy), 1);
    vld_cycles = 0;
    do_enter;
    chk("e420_valid", int'(bus.num_valid), 1);
    chk("e420_value", int'(bus.num_value), 420);
    tick; tick; tick;
    chk("e420_vld_cycles", vld_cycles, 1);
    chk("e420_cnt0", int'(bus.digit_count), 0);
    chk("e420_idle", int'(bus.busy), 0);
    chk("e420_hold_val", int'(bus.num_value), 420);

    // 9 five times: fifth press overflows the digit limit
    err_cnt = 0;
    for (int i = 0; i < 4; i++) press(9);
    chk("full_acc", int'(dut.r_acc), 9999);
    chk("full_state", int'(dut.r_state), int'(ST_FULL));
    chk("full_err0", err_cnt, 0);
    press(9);
    chk("full_err1", err_cnt, 1);
    chk("full_acc_keep", int'(dut.r_acc), 9999);
    chk("full_cnt_keep", int'(bus.digit_count), 4);
    do_enter;
    chk("full_commit", int'(bus.num_value), 9999);
    tick; tick; tick;
    chk("full_idle", int'(bus.busy), 0);

    // 3 and 5 together, then 7 alone
    err_cnt = 0;
    bus.key_in = 10'b00_0010_1000;
    tick; tick;
    bus.key_in = 10'd0;
    tick; tick;
    chk("multi_err", err_cnt, 1);
    chk("multi_cnt", int'(bus.digit_count), 0);
    press(7);
    chk("multi_then7", int'(bus.digit_count), 1);
    chk("multi_acc7", int'(dut.r_acc), 7);
    do_clear;

    // commit 12 while downstream stalls, 8 pressed during HOLD
    bus.num_ready = 1'b0;
    err_cnt = 0;
    press(1);
    press(2);
    do_enter;
    chk("stall_valid", int'(bus.num_valid), 1);
    chk("stall_value", int'(bus.num_value), 12);
    bus.key_in = 10'(1 << 8);
    for (int i = 0; i < 5; i++) tick;
    bus.key_in = 10'd0;
    tick;
    chk("stall_valid_held", int'(bus.num_valid), 1);
    chk("stall_hold", int'(dut.r_state), int'(ST_HOLD));
    chk("stall_cnt", int'(bus.digit_count), 0);
    chk("stall_acc", int'(dut.r_acc), 0);
    chk("stall_err", err_cnt, 0);
    bus.num_ready = 1'b1;
    tick;
    chk("stall_release_vld", int'(bus.num_valid), 0);
    chk("stall_release_idle", int'(bus.busy), 0);
    chk("stall_value_kept", int'(bus.num_value), 12);

    // clear and digit in the same cycle during ENTRY
    err_cnt = 0;
    press(5);
    chk("clr_pre_cnt", int'(bus.digit_count), 1);
    bus.clear  = 1'b1;
    bus.key_in = 10'(1 << 3);
    tick; tick;
    chk("clr_cnt", int'(bus.digit_count), 0);
    chk("clr_idle", int'(bus.busy), 0);
    chk("clr_acc", int'(dut.r_acc), 0);
    bus.clear  = 1'b0;
    bus.key_in = 10'd0;
    tick; tick;
    chk("clr_err", err_cnt, 0);
    bus.num_ready = 1'b0;
    do_enter;
    chk("zero_valid", int'(bus.num_valid), 1);
    chk("zero_value", int'(bus.num_value), 0);
    bus.num_ready = 1'b1;
    tick; tick;

    // async reset mid-cycle while HOLD, key 6 held through release
    bus.num_ready = 1'b0;
    press(3);
    do_enter;
    chk("hold_pre_value", int'(bus.num_value), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.num_valid), 0);
    chk("arst_value", int'(bus.num_value), 0);
    chk("arst_busy", int'(bus.busy), 0);
    bus.enter  = 1'b0;
    bus.key_in = 10'(1 << 6);
    bus.num_ready = 1'b1;
    err_cnt = 0;
    vld_cycles = 0;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    bus.key_in = 10'd0;
    tick; tick;
    chk("arst_key6_cnt", int'(bus.digit_count), 1);
    chk("arst_key6_acc", int'(dut.r_acc), 6);
    chk("arst_no_err", err_cnt, 0);
    chk("arst_no_vld", vld_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
